// File: rtl/tlb_miss_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_miss_ctrl_pkg
// Brief    : Shared MMU constants, FSM state encoding and helper functions
// Revision : 1.0 - initial release
// ============================================================================
package tlb_miss_ctrl_pkg;

    localparam int c_pte_bits    = 32;
    localparam int c_pte_v_bit   = 0;
    localparam int c_pte_pfn_lsb = 10;
    localparam int c_cnt_bits    = 32;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_lookup   = 3'd1;
    localparam logic [2:0] c_st_mem_req  = 3'd2;
    localparam logic [2:0] c_st_mem_wait = 3'd3;
    localparam logic [2:0] c_st_refill   = 3'd4;
    localparam logic [2:0] c_st_resp     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = c_st_idle,
        S_LOOKUP   = c_st_lookup,
        S_MEM_REQ  = c_st_mem_req,
        S_MEM_WAIT = c_st_mem_wait,
        S_REFILL   = c_st_refill,
        S_RESP     = c_st_resp
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_cnt_bits-1:0] sat_inc(input logic [c_cnt_bits-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tlb_miss_ctrl_if
// Brief    : Request/response, TLB lookup/refill and PTE memory port bundle
// Revision : 1.0 - initial release
// ============================================================================
interface tlb_miss_ctrl_if
    import tlb_miss_ctrl_pkg::*;
#(
    parameter int VPN_BITS   = 20,
    parameter int PFN_BITS   = 20,
    parameter int PADDR_BITS = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [VPN_BITS-1:0]   req_vpn;
    logic [PADDR_BITS-1:0] ptbr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [PFN_BITS-1:0]   resp_pfn;
    logic                  resp_fault;
    logic [VPN_BITS-1:0]   tlb_lookup_vpn;
    logic                  tlb_lookup_hit;
    logic [PFN_BITS-1:0]   tlb_lookup_pfn;
    logic                  tlb_refill_en;
    logic [VPN_BITS-1:0]   tlb_refill_vpn;
    logic [PFN_BITS-1:0]   tlb_refill_pfn;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [PADDR_BITS-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [c_pte_bits-1:0] mem_resp_data;

    // Environment side: requester, TLB array and memory.
    modport master (
        output req_valid, req_vpn, ptbr, resp_ready,
        output tlb_lookup_hit, tlb_lookup_pfn,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_pfn, resp_fault,
        input  tlb_lookup_vpn, tlb_refill_en, tlb_refill_vpn, tlb_refill_pfn,
        input  mem_req_valid, mem_req_addr
    );

    // Miss controller side.
    modport slave (
        input  req_valid, req_vpn, ptbr, resp_ready,
        input  tlb_lookup_hit, tlb_lookup_pfn,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_pfn, resp_fault,
        output tlb_lookup_vpn, tlb_refill_en, tlb_refill_vpn, tlb_refill_pfn,
        output mem_req_valid, mem_req_addr
    );
endinterface
`default_nettype wire

// File: rtl/mmu_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_sat_counter
// Brief    : 32-bit event counter with increment enable, saturating at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module mmu_sat_counter
    import tlb_miss_ctrl_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  inc_en,
    output logic      [c_cnt_bits-1:0] count
);
    logic [c_cnt_bits-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc_en) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/tlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_miss_ctrl
// Brief    : TLB lookup plus single-level page-table walk and refill on miss.
//            Optional hit/miss counters when TLB_MISS_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_miss_ctrl
    import tlb_miss_ctrl_pkg::*;
#(
    parameter int VPN_BITS   = 20,
    parameter int PFN_BITS   = 20,
    parameter int PADDR_BITS = 32
)(
    input  wire logic        clk,
    input  wire logic        rst_n,
    tlb_miss_ctrl_if.slave   bus
`ifdef TLB_MISS_PERF_EN
    ,
    output logic [c_cnt_bits-1:0] hit_count,
    output logic [c_cnt_bits-1:0] miss_count
`endif
);
    state_e                r_state;
    state_e                w_next_state;
    logic [VPN_BITS-1:0]   r_vpn;
    logic [PADDR_BITS-1:0] r_ptbr;
    logic [PFN_BITS-1:0]   r_pfn;
    logic                  r_fault;
    logic                  w_pte_valid;
    logic [PFN_BITS-1:0]   w_pte_pfn;
    logic [PADDR_BITS-1:0] w_pte_addr;
    logic                  w_unused_pte;

    assign w_pte_valid  = bus.mem_resp_data[c_pte_v_bit];
    assign w_pte_pfn    = bus.mem_resp_data[c_pte_pfn_lsb +: PFN_BITS];
    assign w_unused_pte = ^bus.mem_resp_data;
    // Built only from latched values, so it stays put across mem_req_ready stalls.
    assign w_pte_addr   = r_ptbr + PADDR_BITS'({r_vpn, 2'b00});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.tlb_refill_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                w_next_state = bus.tlb_lookup_hit ? S_RESP : S_MEM_REQ;
            end
            S_MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) w_next_state = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (bus.mem_resp_valid) w_next_state = w_pte_valid ? S_REFILL : S_RESP;
            end
            S_REFILL: begin
                bus.tlb_refill_en = 1'b1;
                w_next_state      = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vpn   <= '0;
            r_ptbr  <= '0;
            r_pfn   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_vpn  <= bus.req_vpn;
                        r_ptbr <= bus.ptbr;
                    end
                end
                S_LOOKUP: begin
                    if (bus.tlb_lookup_hit) begin
                        r_pfn   <= bus.tlb_lookup_pfn;
                        r_fault <= 1'b0;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        r_pfn   <= w_pte_valid ? w_pte_pfn : '0;
                        r_fault <= ~w_pte_valid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_pfn       = r_pfn;
    assign bus.resp_fault     = r_fault;
    assign bus.tlb_lookup_vpn = r_vpn;
    assign bus.tlb_refill_vpn = r_vpn;
    assign bus.tlb_refill_pfn = r_pfn;
    assign bus.mem_req_addr   = w_pte_addr;

`ifdef TLB_MISS_PERF_EN
    logic w_lookup;
    assign w_lookup = (r_state == S_LOOKUP);

    mmu_sat_counter u_hit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (w_lookup & bus.tlb_lookup_hit),
        .count  (hit_count)
    );

    mmu_sat_counter u_miss_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (w_lookup & ~bus.tlb_lookup_hit),
        .count  (miss_count)
    );
`endif
endmodule
`default_nettype wire

// File: tb/tb_tlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_miss_ctrl
// Brief    : Directed self-checking bench for tlb_miss_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_miss_ctrl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   refill_seen;
    int   mem_req_seen;
    int   snap;

    logic        tlb_hit_en;
    logic [19:0] tlb_vpn;
    logic [19:0] tlb_pfn;
    logic [31:0] ptbr_v;

    tlb_miss_ctrl_if #(.VPN_BITS(20), .PFN_BITS(20), .PADDR_BITS(32)) bus ();

`ifdef TLB_MISS_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    tlb_miss_ctrl #(.VPN_BITS(20), .PFN_BITS(20), .PADDR_BITS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef TLB_MISS_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Single-entry TLB model.
    assign bus.tlb_lookup_hit = tlb_hit_en && (bus.tlb_lookup_vpn == tlb_vpn);
    assign bus.tlb_lookup_pfn = tlb_pfn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tlb_refill_en) refill_seen++;
        if (bus.mem_req_valid) mem_req_seen++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full translation from IDLE back to IDLE with latency checks.
    task automatic xlat(input logic [19:0] vpn, input bit hit, input logic [31:0] pte,
                        input logic [31:0] exp_addr, input logic [19:0] exp_pfn,
                        input bit exp_fault);
        bus.req_valid = 1'b1;
        bus.req_vpn   = vpn;
        bus.ptbr      = ptbr_v;
        check("req_ready_idle", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        bus.ptbr      = 32'hDEAD_0000;
        check("lookup_no_resp", bus.resp_valid, 0);
        check("lookup_vpn", bus.tlb_lookup_vpn, vpn);
        tick();
        if (hit) begin
            check("hit_resp_lat", bus.resp_valid, 1);
        end else begin
            check("miss_mem_req_valid", bus.mem_req_valid, 1);
            check("miss_mem_req_addr", bus.mem_req_addr, exp_addr);
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            check("mem_wait_req_low", bus.mem_req_valid, 0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = pte;
            tick();
            bus.mem_resp_valid = 1'b0;
            if (!exp_fault) begin
                check("refill_en", bus.tlb_refill_en, 1);
                check("refill_vpn", bus.tlb_refill_vpn, vpn);
                check("refill_pfn", bus.tlb_refill_pfn, exp_pfn);
                check("refill_no_resp", bus.resp_valid, 0);
                tick();
                check("refill_one_cycle", bus.tlb_refill_en, 0);
            end
            check("miss_resp_valid", bus.resp_valid, 1);
        end
        check("resp_pfn", bus.resp_pfn, exp_pfn);
        check("resp_fault", bus.resp_fault, exp_fault);
        check("resp_req_ready_low", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("post_resp_valid", bus.resp_valid, 0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        refill_seen       = 0;
        mem_req_seen      = 0;
        ptbr_v            = 32'h8000_0000;
        tlb_hit_en        = 1'b0;
        tlb_vpn           = '0;
        tlb_pfn           = '0;
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_vpn       = '0;
        bus.ptbr          = '0;
        bus.resp_ready    = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_pfn", bus.resp_pfn, 0);
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_mem_req_addr", bus.mem_req_addr, 0);
        check("rst_refill_en", bus.tlb_refill_en, 0);
        check("rst_lookup_vpn", bus.tlb_lookup_vpn, 0);
        rst_n = 1'b1;
        tick();

        // Miss with refill.
        xlat(20'h12345, 1'b0, 32'h002A_F001, 32'h8004_8D14, 20'h00ABC, 1'b0);

        // Hit: no memory traffic.
        tlb_hit_en = 1'b1;
        tlb_vpn    = 20'h12345;
        tlb_pfn    = 20'h00ABC;
        snap = mem_req_seen;
        xlat(20'h12345, 1'b1, 32'h0, 32'h0, 20'h00ABC, 1'b0);
        check("hit_no_mem_req", mem_req_seen, snap);
        tlb_hit_en = 1'b0;

        // Invalid PTE: fault and no refill.
        snap = refill_seen;
        xlat(20'h12345, 1'b0, 32'h002A_F000, 32'h8004_8D14, 20'h0, 1'b1);
        check("fault_no_refill", refill_seen, snap);

        // Backpressure on memory request and on response.
        bus.req_valid = 1'b1;
        bus.req_vpn   = 20'h00010;
        bus.ptbr      = ptbr_v;
        tick();
        bus.req_valid = 1'b0;
        bus.ptbr      = 32'h1234_0000;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_mem_req_valid", bus.mem_req_valid, 1);
            check("bp_mem_req_addr", bus.mem_req_addr, 32'h8000_0040);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_1401;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_resp_valid", bus.resp_valid, 1);
            check("bp_resp_pfn", bus.resp_pfn, 20'h00005);
            check("bp_resp_fault", bus.resp_fault, 0);
            check("bp_req_ready", bus.req_ready, 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("bp_done", bus.req_ready, 1);

        // Reset while waiting for the PTE.
        bus.req_valid = 1'b1;
        bus.req_vpn   = 20'h00ABC;
        bus.ptbr      = ptbr_v;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        snap  = refill_seen;
        rst_n = 1'b0;
        tick();
        check("mid_rst_req_ready", bus.req_ready, 1);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_resp_pfn", bus.resp_pfn, 0);
        check("mid_rst_resp_fault", bus.resp_fault, 0);
        check("mid_rst_mem_req_valid", bus.mem_req_valid, 0);
        check("mid_rst_mem_req_addr", bus.mem_req_addr, 0);
        check("mid_rst_refill_en", bus.tlb_refill_en, 0);
        check("mid_rst_refill_vpn", bus.tlb_refill_vpn, 0);
        check("mid_rst_refill_pfn", bus.tlb_refill_pfn, 0);
        check("mid_rst_lookup_vpn", bus.tlb_lookup_vpn, 0);
        rst_n = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_1401;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        check("stray_req_ready", bus.req_ready, 1);
        check("stray_resp_valid", bus.resp_valid, 0);
        check("stray_no_refill", refill_seen, snap);
        xlat(20'h00001, 1'b0, 32'h0000_0C01, 32'h8000_0004, 20'h00003, 1'b0);

`ifdef TLB_MISS_PERF_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("perf_rst_hits", hit_count, 0);
        tlb_hit_en = 1'b1;
        tlb_vpn    = 20'h12345;
        tlb_pfn    = 20'h00ABC;
        for (int i = 0; i < 3; i++) begin
            xlat(20'h12345, 1'b1, 32'h0, 32'h0, 20'h00ABC, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            xlat(20'h00001, 1'b0, 32'h0000_0C01, 32'h8000_0004, 20'h00003, 1'b0);
        end
        check("perf_hit_count", hit_count, 3);
        check("perf_miss_count", miss_count, 2);
        force dut.u_hit_cnt.r_count = 32'hFFFF_FFFF;
        tick();
        release dut.u_hit_cnt.r_count;
        xlat(20'h12345, 1'b1, 32'h0, 32'h0, 20'h00ABC, 1'b0);
        check("perf_hit_saturate", hit_count, 32'hFFFF_FFFF);
        check("perf_miss_hold", miss_count, 2);
        tlb_hit_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
